// File: rtl/mem_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Core and memory sides both use the rd_req/wr_req pulse plus busy/ack handshake.
module mem_cache_dm #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int num_lines  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_rd_req,
    input  logic                  core_wr_req,
    input  logic [addr_width-1:0] core_addr,
    input  logic [data_width-1:0] core_wr_data,
    output logic [data_width-1:0] core_rd_data,
    output logic                  core_busy,
    output logic                  core_ack,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wr_data,
    input  logic [data_width-1:0] mem_rd_data,
    input  logic                  mem_ack,
    input  logic                  flush,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int idx_w = $clog2(num_lines);
    localparam int tag_w = addr_width - 2 - idx_w;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t state, state_d;

    logic [num_lines-1:0]  valid;
    logic [tag_w-1:0]      tag_mem  [num_lines];
    logic [data_width-1:0] data_mem [num_lines];

    logic [idx_w-1:0] req_idx, fill_idx, line_idx;
    logic [tag_w-1:0] req_tag, fill_tag, line_tag;
    logic [data_width-1:0] line_data;
    logic line_we, line_fill, lookup_hit;

    logic                  core_ack_d, core_busy_d, mem_rd_req_d, mem_wr_req_d;
    logic [data_width-1:0] core_rd_data_d, mem_wr_data_d;
    logic [addr_width-1:0] mem_addr_d;
    logic [31:0]           hit_count_d, miss_count_d;

    assign req_idx  = core_addr[idx_w+1:2];
    assign req_tag  = core_addr[addr_width-1:idx_w+2];
    // mem_addr holds the outstanding miss address, so it also locates the line to fill.
    assign fill_idx = mem_addr[idx_w+1:2];
    assign fill_tag = mem_addr[addr_width-1:idx_w+2];

    // A flush in the same cycle as a lookup forces that lookup to miss.
    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d        = state;
        core_ack_d     = 1'b0;
        core_rd_data_d = '0;
        core_busy_d    = core_busy;
        mem_rd_req_d   = 1'b0;
        mem_wr_req_d   = 1'b0;
        mem_addr_d     = mem_addr;
        mem_wr_data_d  = mem_wr_data;
        hit_count_d    = hit_count;
        miss_count_d   = miss_count;
        line_we        = 1'b0;
        line_fill      = 1'b0;
        line_idx       = req_idx;
        line_tag       = req_tag;
        line_data      = core_wr_data;

        unique case (state)
            IDLE: begin
                if (core_wr_req) begin
                    mem_wr_req_d  = 1'b1;
                    mem_addr_d    = core_addr;
                    mem_wr_data_d = core_wr_data;
                    core_busy_d   = 1'b1;
                    line_we       = lookup_hit;
                    state_d       = WR_WAIT;
                end else if (core_rd_req) begin
                    if (lookup_hit) begin
                        core_ack_d     = 1'b1;
                        core_rd_data_d = data_mem[req_idx];
                        hit_count_d    = hit_count + 32'd1;
                    end else begin
                        mem_rd_req_d = 1'b1;
                        mem_addr_d   = core_addr;
                        core_busy_d  = 1'b1;
                        miss_count_d = miss_count + 32'd1;
                        state_d      = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_ack) begin
                    line_we        = 1'b1;
                    line_fill      = 1'b1;
                    line_idx       = fill_idx;
                    line_tag       = fill_tag;
                    line_data      = mem_rd_data;
                    core_ack_d     = 1'b1;
                    core_rd_data_d = mem_rd_data;
                    core_busy_d    = 1'b0;
                    state_d        = IDLE;
                end
            end
            WR_WAIT: begin
                if (mem_ack) begin
                    core_ack_d  = 1'b1;
                    core_busy_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            core_ack     <= 1'b0;
            core_rd_data <= '0;
            core_busy    <= 1'b0;
            mem_rd_req   <= 1'b0;
            mem_wr_req   <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            state        <= state_d;
            core_ack     <= core_ack_d;
            core_rd_data <= core_rd_data_d;
            core_busy    <= core_busy_d;
            mem_rd_req   <= mem_rd_req_d;
            mem_wr_req   <= mem_wr_req_d;
            mem_addr     <= mem_addr_d;
            mem_wr_data  <= mem_wr_data_d;
            hit_count    <= hit_count_d;
            miss_count   <= miss_count_d;
        end
    end

    // The fill is applied after the flush clear, so a coinciding fill leaves its line valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else begin
            if (flush)
                valid <= '0;
            if (line_fill)
                valid[line_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether their contents count.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[line_idx]  <= line_tag;
            data_mem[line_idx] <= line_data;
        end
    end

endmodule
